// File: rtl/plic_axi_cfg_master.sv
// Single-beat AXI4-Lite-style initiator for the PLIC configuration register bus.
// Turns a local command/response handshake into AW/W/B or AR/R sequences, with a bounded wait per bus state.
module plic_axi_cfg_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   M_AXI_awaddr,
  output logic [2:0]          M_AXI_awprot,
  output logic                M_AXI_awvalid,
  input  logic                M_AXI_awready,
  output logic [DATA_W-1:0]   M_AXI_wdata,
  output logic [DATA_W/8-1:0] M_AXI_wstrb,
  output logic                M_AXI_wvalid,
  input  logic                M_AXI_wready,
  output logic                M_AXI_bready,
  input  logic [1:0]          M_AXI_bresp,
  input  logic                M_AXI_bvalid,
  output logic [ADDR_W-1:0]   M_AXI_araddr,
  output logic [2:0]          M_AXI_arprot,
  output logic                M_AXI_arvalid,
  output logic [7:0]          M_AXI_arlen,
  output logic [2:0]          M_AXI_arsize,
  output logic [1:0]          M_AXI_arburst,
  input  logic                M_AXI_arready,
  output logic                M_AXI_rready,
  input  logic [DATA_W-1:0]   M_AXI_rdata,
  input  logic [1:0]          M_AXI_rresp,
  input  logic                M_AXI_rvalid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                bready_q, bready_d, rready_q, rready_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic                aw_hs, w_hs, tmo_hit, abandon;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b1;
      rready_q      <= 1'b1;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      tcnt_q        <= tcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    tcnt_d        = '0;
    aw_hs         = awvalid_q & M_AXI_awready;
    w_hs          = wvalid_q & M_AXI_wready;
    tmo_hit       = (tcnt_q == TMO_LAST);
    abandon       = 1'b0;

    // Counter advances only while parked in a bus state; any state change clears it.
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          wstrb_d  = cmd_wstrb;
          bready_d = 1'b0;
          rready_d = 1'b0;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (tmo_hit) begin
          abandon = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_bvalid) begin
          state_d       = RESP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = M_AXI_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (tmo_hit) begin
          abandon = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RD_ADDR: begin
        if (M_AXI_arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (tmo_hit) begin
          abandon = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_rvalid) begin
          state_d       = RESP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = M_AXI_rresp;
          rsp_rdata_d   = M_AXI_rdata;
          rsp_timeout_d = 1'b0;
        end else if (tmo_hit) begin
          abandon = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          bready_d    = 1'b1;
          rready_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abandon) begin
      state_d       = RESP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_arlen   = 8'd0;
  assign M_AXI_arsize  = 3'b010;
  assign M_AXI_arburst = 2'b01;
  assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_plic_axi_cfg_master.sv
// Directed bench for plic_axi_cfg_master: the bench plays the PLIC slave and the command source.
module tb_plic_axi_cfg_master;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot, arsize;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [3:0]  wstrb;
  logic        bready, bvalid = 1'b0;
  logic [1:0]  bresp = '0, arburst, rresp = '0;
  logic        arvalid, arready = 1'b0, rready, rvalid = 1'b0;
  logic [7:0]  arlen;
  logic [31:0] rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  plic_axi_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bready(bready), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid),
    .M_AXI_arlen(arlen), .M_AXI_arsize(arsize), .M_AXI_arburst(arburst), .M_AXI_arready(arready),
    .M_AXI_rready(rready), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("const_awprot", awprot, 0);
    chk("const_arprot", arprot, 0);
    aresetn = 1'b1;

    // write 0x8000_0005 -> 0x8, zero-wait slave
    step();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'h8000_0005; cmd_wstrb = 4'hF;
    awready = 1; wready = 1;
    step();
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid", wvalid, 1);
    chk("w1_awaddr", awaddr, 32'h8);
    chk("w1_wdata", wdata, 32'h8000_0005);
    chk("w1_wstrb", wstrb, 4'hF);
    chk("w1_cmd_ready", cmd_ready, 0);
    chk("w1_bready_wr", bready, 0);
    cmd_valid = 0;
    step();
    chk("w1_awvalid_done", awvalid, 0);
    chk("w1_wvalid_done", wvalid, 0);
    chk("w1_bready", bready, 1);
    chk("w1_rsp_early", rsp_valid, 0);
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
    step();
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_resp", rsp_resp, 2'b00);
    chk("w1_rsp_timeout", rsp_timeout, 0);
    chk("w1_rsp_rdata", rsp_rdata, 0);
    bvalid = 0; rsp_ready = 1;
    step();
    chk("w1_rsp_done", rsp_valid, 0);
    chk("w1_cmd_ready", cmd_ready, 1);
    rsp_ready = 0;

    // write with W accepted 4 cycles after AW, SLVERR passthrough
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'h3;
    awready = 1; wready = 0;
    step();
    chk("w2_awvalid", awvalid, 1);
    cmd_valid = 0;
    step();
    chk("w2_awvalid_drop", awvalid, 0);
    chk("w2_wvalid_hold0", wvalid, 1);
    awready = 0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("w2_wvalid_hold%0d", i), wvalid, 1);
      chk($sformatf("w2_wdata_hold%0d", i), wdata, 32'h1234_5678);
      chk($sformatf("w2_awvalid_low%0d", i), awvalid, 0);
    end
    chk("w2_wstrb", wstrb, 4'h3);
    wready = 1;
    step();
    chk("w2_wvalid_done", wvalid, 0);
    chk("w2_bready", bready, 1);
    wready = 0; bvalid = 1; bresp = 2'b10;
    step();
    chk("w2_rsp_valid", rsp_valid, 1);
    chk("w2_rsp_resp", rsp_resp, 2'b10);
    chk("w2_rsp_timeout", rsp_timeout, 0);
    chk("w2_bready_off", bready, 0);
    bvalid = 0; bresp = 2'b00; rsp_ready = 1;
    step();
    chk("w2_rsp_done", rsp_valid, 0);
    rsp_ready = 0;
    step();
    chk("w2_single_rsp", rsp_valid, 0);

    // read 0x4, data after two wait cycles; then backpressured response with a pending command
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4; arready = 1;
    step();
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr", araddr, 32'h4);
    chk("r1_arlen", arlen, 0);
    chk("r1_arsize", arsize, 3'd2);
    chk("r1_arburst", arburst, 2'd1);
    chk("r1_rready_addr", rready, 0);
    cmd_valid = 0;
    step();
    chk("r1_arvalid_drop", arvalid, 0);
    chk("r1_rready", rready, 1);
    arready = 0;
    step();
    chk("r1_wait_rsp", rsp_valid, 0);
    step();
    rvalid = 1; rdata = 32'h0000_0003; rresp = 2'b00;
    step();
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rsp_rdata", rsp_rdata, 32'h3);
    chk("r1_rsp_resp", rsp_resp, 2'b00);
    chk("r1_rsp_timeout", rsp_timeout, 0);
    rvalid = 0; rdata = 32'hFFFF_FFFF;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC; cmd_wdata = 32'h0000_A5A5; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_rsp_valid%0d", i), rsp_valid, 1);
      chk($sformatf("bp_rsp_rdata%0d", i), rsp_rdata, 32'h3);
      chk($sformatf("bp_cmd_ready%0d", i), cmd_ready, 0);
      chk($sformatf("bp_awvalid%0d", i), awvalid, 0);
    end
    rsp_ready = 1;
    step();
    chk("bp_rsp_done", rsp_valid, 0);
    chk("bp_cmd_ready", cmd_ready, 1);
    chk("bp_not_yet", awvalid, 0);
    rsp_ready = 0;
    step();
    chk("bp_accept", awvalid, 1);
    chk("bp_awaddr", awaddr, 32'hC);
    chk("bp_wdata", wdata, 32'h0000_A5A5);
    cmd_valid = 0; awready = 1; wready = 1;

    // asynchronous reset while in WR_RESP
    step();
    chk("rs_bready", bready, 1);
    chk("rs_in_wresp", awvalid, 0);
    awready = 0; wready = 0;
    #2 aresetn = 0;
    #1;
    chk("rs_cmd_ready", cmd_ready, 1);
    chk("rs_awaddr", awaddr, 0);
    chk("rs_wdata", wdata, 0);
    chk("rs_wvalid", wvalid, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    step();
    aresetn = 1; bvalid = 1;
    step();
    chk("rs_stale_drained", rsp_valid, 0);
    chk("rs_idle", cmd_ready, 1);
    bvalid = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = 32'h8000_0001; cmd_wstrb = 4'hF;
    awready = 1; wready = 1;
    step();
    chk("rs_w_awaddr", awaddr, 32'h14);
    cmd_valid = 0;
    step();
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
    step();
    chk("rs_w_rsp_valid", rsp_valid, 1);
    chk("rs_w_rsp_resp", rsp_resp, 2'b00);
    chk("rs_w_rsp_timeout", rsp_timeout, 0);
    bvalid = 0; rsp_ready = 1;
    step();
    chk("rs_w_done", rsp_valid, 0);
    rsp_ready = 0;

    // read with arready never asserted: times out after 8 cycles in RD_ADDR
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("to_arvalid%0d", i), arvalid, 1);
      chk($sformatf("to_rsp_low%0d", i), rsp_valid, 0);
      cmd_valid = 0;
    end
    step();
    chk("to_arvalid_drop", arvalid, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_resp", rsp_resp, 2'b10);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_rready", rready, 0);
    rsp_ready = 1;
    step();
    chk("to_done", rsp_valid, 0);
    rsp_ready = 0;

    // arready in the very cycle the count expires: handshake wins, DECERR passthrough
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h24;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("hw_arvalid%0d", i), arvalid, 1);
      cmd_valid = 0;
    end
    arready = 1;
    step();
    chk("hw_arvalid_drop", arvalid, 0);
    chk("hw_rready", rready, 1);
    chk("hw_no_timeout", rsp_valid, 0);
    arready = 0; rvalid = 1; rdata = 32'h0000_CAFE; rresp = 2'b11;
    step();
    chk("hw_rsp_valid", rsp_valid, 1);
    chk("hw_rsp_rdata", rsp_rdata, 32'h0000_CAFE);
    chk("hw_rsp_resp", rsp_resp, 2'b11);
    chk("hw_rsp_timeout", rsp_timeout, 0);
    rvalid = 0; rsp_ready = 1;
    step();
    chk("hw_done", rsp_valid, 0);
    rsp_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
